// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU-sharing controller: control codes, FSM state, op classifiers.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  // Code driven onto the shared ALU whenever no legal request owns it
  localparam logic [3:0] ALU_CTRL_IDLE = ALU_ADD;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLL,
      ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA: is_legal_op = 1'b1;
      default:                                      is_legal_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_shift_op(input logic [3:0] op);
    is_shift_op = (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: ptr selects the winner only when both requesters are valid.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic ptr,
  input  logic adv,
  output logic gnt,
  output logic gnt_vld,
  output logic ptr_nxt
);

  always_comb begin
    gnt_vld = valid0 | valid1;
    gnt     = (valid0 && valid1) ? ptr : valid1;
    // Priority flips to the loser only when a grant is actually taken
    ptr_nxt = (adv && gnt_vld) ? ~gnt : ptr;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU between two requesters with a single response slot.
// Optional ALU_SHARE_BYPASS_EN: a draining slot accepts a new request on the same edge.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_y,
  output logic            rsp0_zero,
  output logic            rsp0_err,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_y,
  output logic            rsp1_zero,
  output logic            rsp1_err,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_y,
  input  logic            alu_zero
);

  state_t          state, state_nxt;
  logic            ptr, ptr_nxt;
  logic            gnt, gnt_vld;
  logic            slot_open, accept, rsp_take;
  logic [3:0]      sel_op;
  logic [XLEN-1:0] sel_a, sel_b;
  logic            sel_legal;

  logic [XLEN-1:0] y_p1;
  logic            zero_p1, err_p1, owner_p1;

  assign rsp_take = (state == ST_RESP) && (owner_p1 ? rsp1_ready : rsp0_ready);

`ifdef ALU_SHARE_BYPASS_EN
  assign slot_open = (state == ST_IDLE) || rsp_take;
`else
  assign slot_open = (state == ST_IDLE);
`endif

  rr_arb2 u_arb (
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .ptr     (ptr),
    .adv     (slot_open),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .ptr_nxt (ptr_nxt)
  );

  assign accept     = slot_open && gnt_vld;
  assign req0_ready = accept && !gnt;
  assign req1_ready = accept && gnt;

  assign sel_op    = gnt ? req1_op : req0_op;
  assign sel_a     = gnt ? req1_a  : req0_a;
  assign sel_b     = gnt ? req1_b  : req0_b;
  assign sel_legal = is_legal_op(sel_op);

  // Stage p0: drive the shared ALU only for a legal accepted op
  always_comb begin
    alu_ctrl = ALU_CTRL_IDLE;
    alu_a    = '0;
    alu_b    = '0;
    if (accept && sel_legal) begin
      alu_ctrl = sel_op;
      alu_a    = sel_a;
      alu_b    = is_shift_op(sel_op) ? XLEN'(sel_b[SHAMT_W-1:0]) : sel_b;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RESP;
      ST_RESP: if (rsp_take) state_nxt = accept ? ST_RESP : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p1: response slot captured at the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= 1'b0;
      y_p1     <= '0;
      zero_p1  <= 1'b0;
      err_p1   <= 1'b0;
      owner_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (accept) begin
        y_p1     <= sel_legal ? alu_y : '0;
        zero_p1  <= sel_legal && alu_zero;
        err_p1   <= !sel_legal;
        owner_p1 <= gnt;
      end
    end
  end

  assign rsp0_valid = (state == ST_RESP) && !owner_p1;
  assign rsp1_valid = (state == ST_RESP) && owner_p1;
  assign rsp0_y     = rsp0_valid ? y_p1 : '0;
  assign rsp0_zero  = rsp0_valid && zero_p1;
  assign rsp0_err   = rsp0_valid && err_p1;
  assign rsp1_y     = rsp1_valid ? y_p1 : '0;
  assign rsp1_zero  = rsp1_valid && zero_p1;
  assign rsp1_err   = rsp1_valid && err_p1;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural model of the external shared ALU.
module tb_alu_share_ctrl;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]      req0_op, req1_op;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
  logic            rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
  logic            rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
  logic [XLEN-1:0] rsp0_y, rsp1_y;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_a, alu_b, alu_y;
  logic            alu_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.XLEN(XLEN), .SHAMT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y),
    .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y),
    .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_zero(alu_zero)
  );

  // External ALU the controller is meant to drive
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_y = alu_a & alu_b;
      4'b0001: alu_y = alu_a | alu_b;
      4'b0010: alu_y = alu_a + alu_b;
      4'b0110: alu_y = alu_a - alu_b;
      4'b0011: alu_y = alu_a << alu_b[5:0];
      4'b0100: alu_y = {63'd0, $signed(alu_a) < $signed(alu_b)};
      4'b0101: alu_y = {63'd0, alu_a < alu_b};
      4'b0111: alu_y = alu_a ^ alu_b;
      4'b1000: alu_y = alu_a >> alu_b[5:0];
      4'b1010: alu_y = $unsigned($signed(alu_a) >>> alu_b[5:0]);
      default: alu_y = '0;
    endcase
    alu_zero = (alu_y == '0);
  end

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [1:0] exp_gnt [3];
    exp_gnt[0] = 2'd0; exp_gnt[1] = 2'd1; exp_gnt[2] = 2'd0;

    rst_n = 1'b0;
    req0_valid = 0; req0_op = 4'b0010; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_op = 4'b0010; req1_a = '0; req1_b = '0;
    rsp0_ready = 0; rsp1_ready = 0;
    @(negedge clk);
    @(negedge clk);

    // Reset values
    check("rst_req0_ready", 64'(req0_ready), 64'd0);
    check("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
    check("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 64'h2);
    check("rst_alu_a", alu_a, 64'd0);
    check("rst_rsp0_y", rsp0_y, 64'd0);
    rst_n = 1'b1;
    step();

    // ADD 5+7 from requester 0
    req0_valid = 1; req0_op = 4'b0010; req0_a = 64'd5; req0_b = 64'd7;
    @(negedge clk);
    check("add_req0_ready", 64'(req0_ready), 64'd1);
    check("add_alu_ctrl", 64'(alu_ctrl), 64'h2);
    check("add_alu_b", alu_b, 64'd7);
    step();
    req0_valid = 0;
    @(negedge clk);
    check("add_rsp0_valid", 64'(rsp0_valid), 64'd1);
    check("add_rsp0_y", rsp0_y, 64'd12);
    check("add_rsp0_zero", 64'(rsp0_zero), 64'd0);
    check("add_rsp0_err", 64'(rsp0_err), 64'd0);
    check("add_rsp1_valid", 64'(rsp1_valid), 64'd0);
    check("add_req0_ready_busy", 64'(req0_ready), 64'd0);
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;

    // Fresh reset, then both requesting SUB 3-3 continuously
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    req0_valid = 1; req0_op = 4'b0110; req0_a = 64'd3; req0_b = 64'd3;
    req1_valid = 1; req1_op = 4'b0110; req1_a = 64'd3; req1_b = 64'd3;
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 10) begin
        @(negedge clk);
        #1;
        n++;
      end
      check($sformatf("rr_grant%0d", k), {62'd0, req1_ready, req0_ready},
            (exp_gnt[k] == 2'd0) ? 64'd1 : 64'd2);
      step();
      if (k == 2) begin
        req0_valid = 0; req1_valid = 0;
      end
      @(negedge clk);
      #1;
      if (exp_gnt[k] == 2'd0) begin
        check($sformatf("rr_rsp0_valid%0d", k), 64'(rsp0_valid), 64'd1);
        check($sformatf("rr_rsp0_y%0d", k), rsp0_y, 64'd0);
        check($sformatf("rr_rsp0_zero%0d", k), 64'(rsp0_zero), 64'd1);
      end else begin
        check($sformatf("rr_rsp1_valid%0d", k), 64'(rsp1_valid), 64'd1);
        check($sformatf("rr_rsp1_y%0d", k), rsp1_y, 64'd0);
        check($sformatf("rr_rsp1_zero%0d", k), 64'(rsp1_zero), 64'd1);
      end
    end
    step();
    rsp0_ready = 0; rsp1_ready = 0;

    // SLL with shift amount masked to 6 bits
    req1_valid = 1; req1_op = 4'b0011; req1_a = 64'd1; req1_b = 64'h41;
    @(negedge clk);
    check("sll_req1_ready", 64'(req1_ready), 64'd1);
    check("sll_alu_b", alu_b, 64'd1);
    step();
    req1_valid = 0;
    @(negedge clk);
    check("sll_rsp1_valid", 64'(rsp1_valid), 64'd1);
    check("sll_rsp1_y", rsp1_y, 64'd2);
    check("sll_rsp0_y_nonowner", rsp0_y, 64'd0);
    rsp1_ready = 1;
    step();
    rsp1_ready = 0;

    // Illegal code 1111 is accepted but flagged
    req0_valid = 1; req0_op = 4'b1111; req0_a = 64'd9; req0_b = 64'd4;
    @(negedge clk);
    check("ill_req0_ready", 64'(req0_ready), 64'd1);
    check("ill_alu_ctrl", 64'(alu_ctrl), 64'h2);
    check("ill_alu_a", alu_a, 64'd0);
    step();
    req0_valid = 0;
    @(negedge clk);
    check("ill_rsp0_err", 64'(rsp0_err), 64'd1);
    check("ill_rsp0_y", rsp0_y, 64'd0);
    check("ill_rsp0_zero", 64'(rsp0_zero), 64'd0);

    // Backpressure on rsp0 with req1 waiting
    req1_valid = 1; req1_op = 4'b0010; req1_a = 64'd1; req1_b = 64'd1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("bp_req1_ready%0d", c), 64'(req1_ready), 64'd0);
      check($sformatf("bp_rsp0_err%0d", c), 64'(rsp0_err), 64'd1);
      check($sformatf("bp_rsp0_valid%0d", c), 64'(rsp0_valid), 64'd1);
    end
    rsp0_ready = 1;
    #1;
`ifdef ALU_SHARE_BYPASS_EN
    check("bp_req1_same_edge", 64'(req1_ready), 64'd1);
    step();
    rsp0_ready = 0;
`else
    check("bp_req1_bubble", 64'(req1_ready), 64'd0);
    step();
    rsp0_ready = 0;
    @(negedge clk);
    check("bp_req1_after", 64'(req1_ready), 64'd1);
    step();
`endif
    req1_valid = 0;
    @(negedge clk);
    check("bp_rsp1_y", rsp1_y, 64'd2);
    rsp1_ready = 1;
    step();
    rsp1_ready = 0;

    // Reset while a response for requester 0 is pending
    req0_valid = 1; req0_op = 4'b0000; req0_a = 64'hf; req0_b = 64'h3;
    @(negedge clk);
    check("mr_req0_ready", 64'(req0_ready), 64'd1);
    step();
    req0_valid = 0;
    @(negedge clk);
    check("mr_rsp0_y", rsp0_y, 64'h3);
    rst_n = 0;
    #1;
    check("mr_rsp0_valid_drop", 64'(rsp0_valid), 64'd0);
    check("mr_alu_ctrl", 64'(alu_ctrl), 64'h2);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("mr_rsp0_valid_after", 64'(rsp0_valid), 64'd0);
    req1_valid = 1; req1_op = 4'b0010; req1_a = 64'd2; req1_b = 64'd2;
    #1;
    check("mr_req1_alone", 64'(req1_ready), 64'd1);
    req0_valid = 1; req0_op = 4'b0010; req0_a = 64'd1; req0_b = 64'd1;
    #1;
    check("mr_ptr0_req0_wins", {62'd0, req1_ready, req0_ready}, 64'd1);
    step();
    req0_valid = 0;
    @(negedge clk);
    check("mr_rsp0_y_new", rsp0_y, 64'd2);
    req1_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
